// File: rtl/snitch_perf_counter_bank.sv
// rtl/snitch_perf_counter_bank.sv - Performance-counter bank with saturation, flags, thresholds, freeze and snapshot
module snitch_perf_counter_bank #(
    parameter int unsigned NumCounters  = 8,
    parameter int unsigned CounterWidth = 48,
    parameter int unsigned NumEvents    = 32,
    parameter int unsigned IncWidth     = 4,
    localparam int unsigned SelWidth    = (NumEvents > 1) ? $clog2(NumEvents) : 1,
    localparam int unsigned IdxWidth    = $clog2(NumCounters) + 1
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [NumEvents*IncWidth-1:0] event_inc_i,
    input  logic                          freeze_i,
    input  logic                          snapshot_i,
    input  logic                          wr_en_i,
    input  logic [IdxWidth-1:0]           wr_idx_i,
    input  logic [1:0]                    wr_field_i,
    input  logic [CounterWidth-1:0]       wr_data_i,
    input  logic [IdxWidth-1:0]           rd_idx_i,
    input  logic                          rd_shadow_i,
    output logic [CounterWidth-1:0]       rd_value_o,
    output logic [NumCounters-1:0]        overflow_o,
    output logic [NumCounters-1:0]        thr_hit_o,
    output logic                          irq_o
);

    typedef logic [CounterWidth-1:0] cnt_t;

    cnt_t                 cnt_q    [NumCounters];
    cnt_t                 cnt_d    [NumCounters];
    cnt_t                 thr_q    [NumCounters];
    cnt_t                 thr_d    [NumCounters];
    cnt_t                 shadow_q [NumCounters];
    cnt_t                 shadow_d [NumCounters];
    logic [SelWidth-1:0]  sel_q    [NumCounters];
    logic [SelWidth-1:0]  sel_d    [NumCounters];
    logic [IncWidth-1:0]  inc_q    [NumEvents];
    logic [IncWidth-1:0]  inc_d    [NumEvents];
    logic [NumCounters-1:0] en_q, en_d, sat_q, sat_d, irq_en_q, irq_en_d;
    logic [NumCounters-1:0] ovf_q, ovf_d, hit_q, hit_d;

    logic [IncWidth-1:0]   inc_sel;
    logic [CounterWidth:0] sum;
    cnt_t                  nxt;
    logic                  set_ovf;
    logic                  set_hit;
    logic                  wr_sel;

    // Next-state for the event stage and every counter: increment, write, flags, snapshot
    always_comb begin
        inc_sel = '0;
        sum     = '0;
        nxt     = '0;
        set_ovf = 1'b0;
        set_hit = 1'b0;
        wr_sel  = 1'b0;
        // Event stage loads unconditionally; freeze only gates the counters
        for (int e = 0; e < NumEvents; e++) begin
            inc_d[e] = event_inc_i[e*IncWidth +: IncWidth];
        end
        for (int i = 0; i < NumCounters; i++) begin
            en_d[i]     = en_q[i];
            sat_d[i]    = sat_q[i];
            irq_en_d[i] = irq_en_q[i];
            sel_d[i]    = sel_q[i];
            thr_d[i]    = thr_q[i];
            shadow_d[i] = snapshot_i ? cnt_q[i] : shadow_q[i];

            // Selects beyond the populated event range contribute nothing
            inc_sel = '0;
            if (32'(sel_q[i]) < NumEvents) begin
                inc_sel = inc_q[sel_q[i]];
            end
            sum     = {1'b0, cnt_q[i]} + (CounterWidth+1)'(inc_sel);
            set_ovf = 1'b0;
            nxt     = cnt_q[i];
            wr_sel  = wr_en_i && (wr_idx_i == IdxWidth'(i));

            // A value write wins over that cycle's increment
            if (wr_sel && wr_field_i == 2'd1) begin
                nxt = wr_data_i;
            end else if (en_q[i] && !freeze_i) begin
                if (sum[CounterWidth]) begin
                    set_ovf = 1'b1;
                    nxt     = sat_q[i] ? '1 : sum[CounterWidth-1:0];
                end else begin
                    nxt = sum[CounterWidth-1:0];
                end
            end
            cnt_d[i] = nxt;

            // Crossing is judged on the old and new value, so a wrap that ends below
            // the threshold never registers as a hit
            set_hit  = (thr_q[i] != '0) && (cnt_q[i] < thr_q[i]) && (nxt >= thr_q[i]);
            ovf_d[i] = ovf_q[i] | set_ovf;
            hit_d[i] = hit_q[i] | set_hit;

            if (wr_sel && wr_field_i == 2'd0) begin
                en_d[i]     = wr_data_i[0];
                sat_d[i]    = wr_data_i[1];
                irq_en_d[i] = wr_data_i[2];
                sel_d[i]    = wr_data_i[8 +: SelWidth];
                // clear_flags is not stored and overrides any same-cycle set
                if (wr_data_i[3]) begin
                    ovf_d[i] = 1'b0;
                    hit_d[i] = 1'b0;
                end
            end
            if (wr_sel && wr_field_i == 2'd2) begin
                thr_d[i] = wr_data_i;
            end
        end
    end

    // State registers with synchronous active-high reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < NumCounters; i++) begin
                cnt_q[i]    <= '0;
                thr_q[i]    <= '0;
                shadow_q[i] <= '0;
                sel_q[i]    <= '0;
            end
            for (int e = 0; e < NumEvents; e++) begin
                inc_q[e] <= '0;
            end
            en_q     <= '0;
            sat_q    <= '0;
            irq_en_q <= '0;
            ovf_q    <= '0;
            hit_q    <= '0;
        end else begin
            cnt_q    <= cnt_d;
            thr_q    <= thr_d;
            shadow_q <= shadow_d;
            sel_q    <= sel_d;
            inc_q    <= inc_d;
            en_q     <= en_d;
            sat_q    <= sat_d;
            irq_en_q <= irq_en_d;
            ovf_q    <= ovf_d;
            hit_q    <= hit_d;
        end
    end

    // Read mux and flag outputs draw only on registered state
    always_comb begin
        rd_value_o = '0;
        if (32'(rd_idx_i) < NumCounters) begin
            rd_value_o = rd_shadow_i ? shadow_q[rd_idx_i] : cnt_q[rd_idx_i];
        end
        overflow_o = ovf_q;
        thr_hit_o  = hit_q;
        irq_o      = |(hit_q & irq_en_q);
    end

endmodule

// File: tb/tb_snitch_perf_counter_bank.sv
// tb/tb_snitch_perf_counter_bank.sv - Directed self-checking bench for snitch_perf_counter_bank
module tb_snitch_perf_counter_bank;

    localparam int N  = 4;
    localparam int CW = 16;
    localparam int NE = 8;
    localparam int IW = 4;
    localparam int XW = $clog2(N) + 1;

    logic           clk = 1'b0;
    logic           rst;
    logic [NE*IW-1:0] event_inc;
    logic           freeze;
    logic           snapshot;
    logic           wr_en;
    logic [XW-1:0]  wr_idx;
    logic [1:0]     wr_field;
    logic [CW-1:0]  wr_data;
    logic [XW-1:0]  rd_idx;
    logic           rd_shadow;
    logic [CW-1:0]  rd_value;
    logic [N-1:0]   overflow;
    logic [N-1:0]   thr_hit;
    logic           irq;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    snitch_perf_counter_bank #(
        .NumCounters (N),
        .CounterWidth(CW),
        .NumEvents   (NE),
        .IncWidth    (IW)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .event_inc_i(event_inc),
        .freeze_i   (freeze),
        .snapshot_i (snapshot),
        .wr_en_i    (wr_en),
        .wr_idx_i   (wr_idx),
        .wr_field_i (wr_field),
        .wr_data_i  (wr_data),
        .rd_idx_i   (rd_idx),
        .rd_shadow_i(rd_shadow),
        .rd_value_o (rd_value),
        .overflow_o (overflow),
        .thr_hit_o  (thr_hit),
        .irq_o      (irq)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_rd(input string tag, input int idx, input logic sh, input logic [31:0] exp);
        rd_idx    = XW'(idx);
        rd_shadow = sh;
        #1;
        chk(tag, 32'(rd_value), exp);
    endtask

    task automatic wr(input int idx, input int field, input logic [CW-1:0] data);
        wr_en    = 1'b1;
        wr_idx   = XW'(idx);
        wr_field = 2'(field);
        wr_data  = data;
        tick();
        wr_en    = 1'b0;
    endtask

    task automatic set_ev(input int e, input int v);
        event_inc = '0;
        event_inc[e*IW +: IW] = IW'(v);
    endtask

    initial begin
        rst = 1'b1; event_inc = '0; freeze = 1'b0; snapshot = 1'b0;
        wr_en = 1'b0; wr_idx = '0; wr_field = '0; wr_data = '0;
        rd_idx = '0; rd_shadow = 1'b0;
        tick(); tick();
        rst = 1'b0;

        // Reset state
        chk_rd("rst_live", 0, 1'b0, 32'h0);
        chk_rd("rst_shadow", 0, 1'b1, 32'h0);
        chk("rst_ovf", 32'(overflow), 32'h0);
        chk("rst_hit", 32'(thr_hit), 32'h0);
        chk("rst_irq", 32'(irq), 32'h0);

        // Counter 0 counts event 3 by 2 for 5 cycles, two-cycle latency
        wr(0, 0, 16'h0301);
        set_ev(3, 2);
        tick();
        chk_rd("lat_edge_k", 0, 1'b0, 32'h0);
        tick();
        chk_rd("lat_edge_k1", 0, 1'b0, 32'h2);
        tick(); tick(); tick();
        event_inc = '0;
        tick();
        chk_rd("count_10", 0, 1'b0, 32'd10);
        tick();
        chk_rd("count_hold", 0, 1'b0, 32'd10);

        // Wrap mode overflow and clear_flags
        wr(0, 1, 16'hFFFE);
        chk_rd("wr_visible", 0, 1'b0, 32'hFFFE);
        set_ev(3, 3);
        tick();
        event_inc = '0;
        tick();
        chk_rd("wrap_val", 0, 1'b0, 32'h0001);
        chk("wrap_ovf", 32'(overflow), 32'h1);
        wr(0, 0, 16'h0309);
        chk("clr_ovf", 32'(overflow), 32'h0);
        chk_rd("clr_val", 0, 1'b0, 32'h0001);

        // Saturate mode on counter 1, event 2
        wr(1, 0, 16'h0203);
        wr(1, 1, 16'hFFFE);
        set_ev(2, 3);
        tick();
        event_inc = '0;
        tick();
        chk_rd("sat_val", 1, 1'b0, 32'hFFFF);
        chk("sat_ovf", 32'(overflow), 32'h2);
        tick();
        chk_rd("sat_hold", 1, 1'b0, 32'hFFFF);
        wr(1, 0, 16'h020B);
        chk("sat_clr", 32'(overflow), 32'h0);
        set_ev(2, 1);
        tick();
        event_inc = '0;
        tick();
        chk("sat_reovf", 32'(overflow), 32'h2);
        chk_rd("sat_val2", 1, 1'b0, 32'hFFFF);

        // Threshold 100 on counter 2, event 4
        wr(2, 0, 16'h0405);
        wr(2, 2, 16'd100);
        wr(2, 1, 16'd98);
        set_ev(4, 1);
        tick();
        chk_rd("thr_98", 2, 1'b0, 32'd98);
        tick();
        chk_rd("thr_99", 2, 1'b0, 32'd99);
        chk("thr_below", 32'(thr_hit), 32'h0);
        chk("irq_below", 32'(irq), 32'h0);
        tick();
        chk_rd("thr_100", 2, 1'b0, 32'd100);
        chk("thr_hit", 32'(thr_hit), 32'h4);
        chk("irq_hit", 32'(irq), 32'h1);
        event_inc = '0;
        tick();
        chk_rd("thr_101", 2, 1'b0, 32'd101);
        wr(2, 1, 16'd0);
        chk_rd("thr_wr0", 2, 1'b0, 32'h0);
        chk("irq_sticky", 32'(irq), 32'h1);
        wr(2, 0, 16'h040D);
        chk("thr_clr", 32'(thr_hit), 32'h0);
        chk("irq_clr", 32'(irq), 32'h0);

        // Value write beats same-cycle increment; freeze holds the counter
        wr(3, 0, 16'h0601);
        set_ev(6, 5);
        tick();
        event_inc = '0;
        wr(3, 1, 16'h1234);
        chk_rd("wrwin_0", 3, 1'b0, 32'h1234);
        tick();
        chk_rd("wrwin_1", 3, 1'b0, 32'h1234);
        set_ev(6, 1);
        freeze = 1'b1;
        tick(); tick(); tick(); tick();
        chk_rd("freeze", 3, 1'b0, 32'h1234);
        freeze = 1'b0;
        event_inc = '0;
        tick();
        chk_rd("unfreeze", 3, 1'b0, 32'h1235);

        // Snapshot captures the pre-edge value and holds
        set_ev(3, 1);
        tick(); tick();
        chk_rd("pre_snap", 0, 1'b0, 32'h2);
        snapshot = 1'b1;
        tick();
        snapshot = 1'b0;
        chk_rd("snap_shadow", 0, 1'b1, 32'h2);
        chk_rd("snap_live", 0, 1'b0, 32'h3);
        tick();
        event_inc = '0;
        tick();
        chk_rd("snap_hold", 0, 1'b1, 32'h2);
        chk_rd("live_run", 0, 1'b0, 32'h5);
        chk_rd("snap_c1", 1, 1'b1, 32'hFFFF);
        chk_rd("snap_c3", 3, 1'b1, 32'h1235);
        chk_rd("oor_live", 4, 1'b0, 32'h0);
        chk_rd("oor_shadow", 7, 1'b1, 32'h0);

        // Mid-operation reset discards state and same-cycle events
        set_ev(3, 7);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        event_inc = '0;
        chk_rd("mrst_live", 0, 1'b0, 32'h0);
        chk_rd("mrst_shadow", 0, 1'b1, 32'h0);
        chk("mrst_ovf", 32'(overflow), 32'h0);
        tick();
        chk_rd("mrst_after", 0, 1'b0, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
